// File: rtl/bram_pkg.sv
// Shared sizing helpers and read-during-write mode names for the single-macro block RAM.
package bram_pkg;

  localparam int ARRAY_BITS = 16384;

  localparam string MODE_WRITE_FIRST = "WRITE_FIRST";
  localparam string MODE_READ_FIRST  = "READ_FIRST";
  localparam string MODE_NO_CHANGE   = "NO_CHANGE";

  // Word pitch inside the array: next power of two at or above the data width.
  function automatic int calc_stride(input int width);
    int s;
    s = 1;
    while (s < width) s = s * 2;
    return s;
  endfunction

  function automatic int calc_depth(input int width);
    return ARRAY_BITS / calc_stride(width);
  endfunction

endpackage

// File: rtl/bram_output_stage.sv
// Read latch with asynchronous clear, plus an optional pipeline register behind it.
module bram_output_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int DO_REG     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data_o
);

  // The RAM read register itself has no reset; a cleared valid flag masks it
  // to zero until the first read after reset refreshes it.
  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
    end
  end

  assign latch = valid_reg ? word : '0;

  generate
    if (DO_REG != 0) begin : g_do_reg
      logic [DATA_WIDTH-1:0] out_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_reg <= '0;
        end else begin
          out_reg <= latch;
        end
      end

      assign data_o = out_reg;
    end else begin : g_no_reg
      assign data_o = latch;
    end
  endgenerate

endmodule

// File: rtl/bram_single_macro.sv
// Single-port 16Kb data array with byte-lane writes, selectable read-during-write
// behaviour and an optional output register.
module bram_single_macro
  import bram_pkg::*;
#(
  parameter int           DATA_WIDTH = 16,
  parameter int           DO_REG     = 0,
  parameter string        WRITE_MODE = "NO_CHANGE",
  parameter logic [255:0] INIT_00 = '0, INIT_01 = '0, INIT_02 = '0, INIT_03 = '0,
  parameter logic [255:0] INIT_04 = '0, INIT_05 = '0, INIT_06 = '0, INIT_07 = '0,
  parameter logic [255:0] INIT_08 = '0, INIT_09 = '0, INIT_0A = '0, INIT_0B = '0,
  parameter logic [255:0] INIT_0C = '0, INIT_0D = '0, INIT_0E = '0, INIT_0F = '0,
  parameter logic [255:0] INIT_10 = '0, INIT_11 = '0, INIT_12 = '0, INIT_13 = '0,
  parameter logic [255:0] INIT_14 = '0, INIT_15 = '0, INIT_16 = '0, INIT_17 = '0,
  parameter logic [255:0] INIT_18 = '0, INIT_19 = '0, INIT_1A = '0, INIT_1B = '0,
  parameter logic [255:0] INIT_1C = '0, INIT_1D = '0, INIT_1E = '0, INIT_1F = '0,
  parameter logic [255:0] INIT_20 = '0, INIT_21 = '0, INIT_22 = '0, INIT_23 = '0,
  parameter logic [255:0] INIT_24 = '0, INIT_25 = '0, INIT_26 = '0, INIT_27 = '0,
  parameter logic [255:0] INIT_28 = '0, INIT_29 = '0, INIT_2A = '0, INIT_2B = '0,
  parameter logic [255:0] INIT_2C = '0, INIT_2D = '0, INIT_2E = '0, INIT_2F = '0,
  parameter logic [255:0] INIT_30 = '0, INIT_31 = '0, INIT_32 = '0, INIT_33 = '0,
  parameter logic [255:0] INIT_34 = '0, INIT_35 = '0, INIT_36 = '0, INIT_37 = '0,
  parameter logic [255:0] INIT_38 = '0, INIT_39 = '0, INIT_3A = '0, INIT_3B = '0,
  parameter logic [255:0] INIT_3C = '0, INIT_3D = '0, INIT_3E = '0, INIT_3F = '0,
  localparam int STRIDE     = calc_stride(DATA_WIDTH),
  localparam int DEPTH      = calc_depth(DATA_WIDTH),
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int WE_WIDTH   = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [WE_WIDTH-1:0]   we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] di,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam bit IS_WRITE_FIRST = (WRITE_MODE == MODE_WRITE_FIRST);
  localparam bit IS_NO_CHANGE   = (WRITE_MODE == MODE_NO_CHANGE);

  localparam logic [ARRAY_BITS-1:0] INIT_VEC = {
    INIT_3F, INIT_3E, INIT_3D, INIT_3C, INIT_3B, INIT_3A, INIT_39, INIT_38,
    INIT_37, INIT_36, INIT_35, INIT_34, INIT_33, INIT_32, INIT_31, INIT_30,
    INIT_2F, INIT_2E, INIT_2D, INIT_2C, INIT_2B, INIT_2A, INIT_29, INIT_28,
    INIT_27, INIT_26, INIT_25, INIT_24, INIT_23, INIT_22, INIT_21, INIT_20,
    INIT_1F, INIT_1E, INIT_1D, INIT_1C, INIT_1B, INIT_1A, INIT_19, INIT_18,
    INIT_17, INIT_16, INIT_15, INIT_14, INIT_13, INIT_12, INIT_11, INIT_10,
    INIT_0F, INIT_0E, INIT_0D, INIT_0C, INIT_0B, INIT_0A, INIT_09, INIT_08,
    INIT_07, INIT_06, INIT_05, INIT_04, INIT_03, INIT_02, INIT_01, INIT_00
  };

  typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

  // Unused bits between DATA_WIDTH and STRIDE are simply skipped.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = INIT_VEC[i*STRIDE +: DATA_WIDTH];
    end
    return m;
  endfunction

  mem_t mem = init_mem();

  logic                  wr_en;
  logic                  load;
  logic [DATA_WIDTH-1:0] rd_reg;

  // Sampling rst_n here keeps writes and reads off while the port is held in reset.
  assign wr_en = en && rst_n && (|we);
  assign load  = en && rst_n && (!(|we) || !IS_NO_CHANGE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        if (we[b/8]) mem[addr][b] <= di[b];
      end
    end
    if (load) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        rd_reg[b] <= (IS_WRITE_FIRST && we[b/8]) ? di[b] : mem[addr][b];
      end
    end
  end

  bram_output_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DO_REG     (DO_REG)
  ) u_output_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .word   (rd_reg),
    .data_o (data_o)
  );

endmodule

// File: tb/tb_bram_single_macro.sv
// Four differently configured instances driven by one stimulus stream and checked
// against a plain array model of the documented read/write rules.
module tb_bram_single_macro;

  localparam logic [255:0] I00 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_BEEF;
  localparam logic [255:0] I01 = 256'hDEAD_5A5A_1357_2468_ACE0_BDF1_0000_FFFF_8001_7FFE_3C3C_C3C3_9999_6666_1111_EEEE;
  localparam logic [255:0] I3F = 256'hCAFE_F00D_0BAD_BEEF_1234_5678_9ABC_DEF0_AAAA_5555_0F0F_F0F0_00FF_FF00_7777_8888;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  we;
  logic [9:0]  addr;
  logic [15:0] di;
  logic [15:0] q_nc, q_wf, q_rf;
  logic [9:0]  q_10;

  always #5 clk = ~clk;

  bram_single_macro #(.DATA_WIDTH(16), .DO_REG(0), .WRITE_MODE("NO_CHANGE"),
                      .INIT_00(I00), .INIT_01(I01), .INIT_3F(I3F))
    u_nc (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .di(di), .data_o(q_nc));
  bram_single_macro #(.DATA_WIDTH(16), .DO_REG(1), .WRITE_MODE("WRITE_FIRST"),
                      .INIT_00(I00), .INIT_01(I01), .INIT_3F(I3F))
    u_wf (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .di(di), .data_o(q_wf));
  bram_single_macro #(.DATA_WIDTH(16), .DO_REG(0), .WRITE_MODE("READ_FIRST"),
                      .INIT_00(I00), .INIT_01(I01), .INIT_3F(I3F))
    u_rf (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .di(di), .data_o(q_rf));
  bram_single_macro #(.DATA_WIDTH(10), .DO_REG(0), .WRITE_MODE("NO_CHANGE"),
                      .INIT_00(I00), .INIT_01(I01), .INIT_3F(I3F))
    u_10 (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .di(di[9:0]), .data_o(q_10));

  // Reference model: one word array per instance, latch value and output register.
  logic [15:0] m_nc [1024];
  logic [15:0] m_wf [1024];
  logic [15:0] m_rf [1024];
  logic [9:0]  m_10 [1024];
  logic [15:0] l_nc, l_wf, l_rf, o_wf;
  logic [9:0]  l_10;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_init();
    logic [16383:0] init_vec;
    init_vec = '0;
    init_vec[255:0]       = I00;
    init_vec[511:256]     = I01;
    init_vec[16383:16128] = I3F;
    for (int k = 0; k < 1024; k++) begin
      m_nc[k] = init_vec[k*16 +: 16];
      m_wf[k] = init_vec[k*16 +: 16];
      m_rf[k] = init_vec[k*16 +: 16];
      m_10[k] = init_vec[k*16 +: 10];
    end
  endtask

  task automatic model_reset();
    l_nc = '0; l_wf = '0; l_rf = '0; l_10 = '0; o_wf = '0;
  endtask

  // What one rising edge does, given the inputs present at that edge.
  task automatic model_edge();
    logic [15:0] mask, old16, new16;
    logic [9:0]  old10, new10;
    if (rst_n) begin
      o_wf = l_wf;
      if (en) begin
        mask  = {{8{we[1]}}, {8{we[0]}}};
        old16 = m_nc[addr];
        new16 = (old16 & ~mask) | (di & mask);
        old10 = m_10[addr];
        new10 = (old10 & ~mask[9:0]) | (di[9:0] & mask[9:0]);
        if (we == 2'b00) begin
          l_nc = m_nc[addr]; l_wf = m_wf[addr]; l_rf = m_rf[addr]; l_10 = m_10[addr];
        end else begin
          l_wf = (m_wf[addr] & ~mask) | (di & mask);
          l_rf = m_rf[addr];
          m_nc[addr] = new16;
          m_wf[addr] = (m_wf[addr] & ~mask) | (di & mask);
          m_rf[addr] = (m_rf[addr] & ~mask) | (di & mask);
          m_10[addr] = new10;
        end
      end
    end
  endtask

  task automatic check_all();
    check_eq("nc_out", {16'h0, q_nc}, {16'h0, l_nc});
    check_eq("wf_out", {16'h0, q_wf}, {16'h0, o_wf});
    check_eq("rf_out", {16'h0, q_rf}, {16'h0, l_rf});
    check_eq("w10_out", {22'h0, q_10}, {22'h0, l_10});
  endtask

  task automatic drive(input logic e, input logic [1:0] w, input logic [9:0] a, input logic [15:0] d);
    en = e; we = w; addr = a; di = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    model_init();
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 10'd0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Plain read of the initialised word 0.
    drive(1'b1, 2'b00, 10'd0, 16'h0);
    step();
    check_eq("beef_nc", {16'h0, q_nc}, 32'hBEEF);
    check_eq("beef_w10", {22'h0, q_10}, 32'h2EF);
    check_eq("beef_doreg_early", {16'h0, q_wf}, 32'h0);
    drive(1'b0, 2'b00, 10'd0, 16'h0);
    step();
    check_eq("beef_doreg", {16'h0, q_wf}, 32'hBEEF);

    // Full write, then byte-lane write, then read back.
    drive(1'b1, 2'b11, 10'd5, 16'h1234);
    step();
    check_eq("nc_hold", {16'h0, q_nc}, 32'hBEEF);
    drive(1'b1, 2'b00, 10'd5, 16'h0);
    step();
    check_eq("nc_rd5", {16'h0, q_nc}, 32'h1234);
    drive(1'b1, 2'b01, 10'd5, 16'hAA55);
    step();
    check_eq("rf_prewrite", {16'h0, q_rf}, 32'h1234);
    drive(1'b1, 2'b00, 10'd5, 16'h0);
    step();
    check_eq("wf_merged", {16'h0, q_wf}, 32'h1255);
    check_eq("nc_merged", {16'h0, q_nc}, 32'h1255);

    // Reset asserted before a pending read edge: output clears, read and write are dropped.
    drive(1'b1, 2'b00, 10'd0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_clear", {16'h0, q_nc}, 32'h0);
    drive(1'b1, 2'b11, 10'd5, 16'hFFFF);
    step();
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 10'd0, 16'h0);
    step();
    check_eq("rst_hold", {16'h0, q_nc}, 32'h0);
    drive(1'b1, 2'b00, 10'd5, 16'h0);
    step();
    check_eq("rst_keep_array", {16'h0, q_nc}, 32'h1255);

    // Address sweep over every word with reads only.
    for (int k = 0; k < 1024; k++) begin
      drive(1'b1, 2'b00, k[9:0], 16'h0);
      step();
    end

    // Random traffic concentrated on a few addresses, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            {($urandom_range(0, 1) != 0) ? 6'h3F : 6'h00, 4'($urandom_range(0, 15))},
            16'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
